// File: rtl/regfile_pkg.sv
// Shared constants, byte-lane helpers and the lane-merge function for the register bank.
// Merge arithmetic is done at REGFILE_MAX_WIDTH so any DATA_WIDTH up to that limit can reuse it.
package regfile_pkg;

  localparam int REGFILE_DATA_WIDTH = 32;
  localparam int REGFILE_NUM_REGS   = 16;
  localparam int REGFILE_MAX_WIDTH  = 512;
  localparam int REGFILE_MAX_LANES  = REGFILE_MAX_WIDTH / 8;

  typedef logic [REGFILE_DATA_WIDTH/8-1:0] regfile_be_t;

  function automatic int byte_lanes(input int width);
    return width / 8;
  endfunction

  // Enabled lanes take the new byte; disabled lanes keep the old byte.
  function automatic logic [REGFILE_MAX_WIDTH-1:0] merge_bytes(
    input logic [REGFILE_MAX_WIDTH-1:0] old_word,
    input logic [REGFILE_MAX_WIDTH-1:0] new_word,
    input logic [REGFILE_MAX_LANES-1:0] be
  );
    logic [REGFILE_MAX_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < REGFILE_MAX_LANES; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/regfile_cell.sv
// One storage word with async clear, per-byte write enables and its merged next value.
// The next value is exported so the bank can forward it onto read ports.
module regfile_cell
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = REGFILE_DATA_WIDTH
) (
  input  logic                               clock,
  input  logic                               clear,
  input  logic                               load,
  input  logic [byte_lanes(DATA_WIDTH)-1:0]  be,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  output logic [DATA_WIDTH-1:0]              q,
  output logic [DATA_WIDTH-1:0]              next
);

  assign next = DATA_WIDTH'(merge_bytes(REGFILE_MAX_WIDTH'(q),
                                        REGFILE_MAX_WIDTH'(wr_data),
                                        REGFILE_MAX_LANES'(be)));

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= next;
    end
  end

endmodule

// File: rtl/regfile_bank.sv
// Multi-register bank: one byte-enabled write port, two combinational read ports with optional
// write-through forwarding. Define REGFILE_R0_ZERO_EN to hardwire register 0 to zero.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
  parameter int NUM_REGS   = REGFILE_NUM_REGS,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int BYPASS     = 1
) (
  input  logic                               clock,
  input  logic                               clear,
  input  logic                               wr_en,
  input  logic [ADDR_WIDTH-1:0]              wr_addr,
  input  logic [byte_lanes(DATA_WIDTH)-1:0]  wr_be,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic [ADDR_WIDTH-1:0]              rd_addr_a,
  output logic [DATA_WIDTH-1:0]              rd_data_a,
  input  logic [ADDR_WIDTH-1:0]              rd_addr_b,
  output logic [DATA_WIDTH-1:0]              rd_data_b
);

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] stored [NUM_REGS];
  logic [DATA_WIDTH-1:0] merged [NUM_REGS];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (R0_ZERO && i == 0) begin : g_zero
      // Constant zero for both stored and forwarded value keeps R0 out of the bypass path too.
      assign stored[i] = '0;
      assign merged[i] = '0;
    end else begin : g_cell
      regfile_cell #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_cell (
        .clock   (clock),
        .clear   (clear),
        .load    (wr_en && (wr_addr == ADDR_WIDTH'(i))),
        .be      (wr_be),
        .wr_data (wr_data),
        .q       (stored[i]),
        .next    (merged[i])
      );
    end
  end

  always_comb begin
    rd_data_a = stored[rd_addr_a];
    if (BYPASS != 0 && wr_en && rd_addr_a == wr_addr) rd_data_a = merged[wr_addr];
    if (clear) rd_data_a = '0;
  end

  always_comb begin
    rd_data_b = stored[rd_addr_b];
    if (BYPASS != 0 && wr_en && rd_addr_b == wr_addr) rd_data_b = merged[wr_addr];
    if (clear) rd_data_b = '0;
  end

endmodule

// File: tb/tb_regfile_bank.sv
// Directed bench for regfile_bank: one instance with forwarding, one without.
// Expectations follow REGFILE_R0_ZERO_EN when the bench is built with that macro.
module tb_regfile_bank;
  import regfile_pkg::*;

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear;
  logic        wr_en;
  logic [3:0]  wr_addr;
  regfile_be_t wr_be;
  logic [31:0] wr_data;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_a_byp, rd_b_byp, rd_a_nb, rd_b_nb;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  regfile_bank dut (
    .clock (clock), .clear (clear), .wr_en (wr_en), .wr_addr (wr_addr),
    .wr_be (wr_be), .wr_data (wr_data),
    .rd_addr_a (rd_addr_a), .rd_data_a (rd_a_byp),
    .rd_addr_b (rd_addr_b), .rd_data_b (rd_b_byp)
  );

  regfile_bank #(.BYPASS(0)) dut_nb (
    .clock (clock), .clear (clear), .wr_en (wr_en), .wr_addr (wr_addr),
    .wr_be (wr_be), .wr_data (wr_data),
    .rd_addr_a (rd_addr_a), .rd_data_a (rd_a_nb),
    .rd_addr_b (rd_addr_b), .rd_data_b (rd_b_nb)
  );

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] ea;   // forwarding instance
    logic [31:0] eb;
    logic [31:0] na;   // non-forwarding instance
    logic [31:0] nb;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [3:0] be,
                       input logic [31:0] wd, input logic [3:0] ra, input logic [3:0] rb);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb;
  endtask

  task automatic check_all(input string name, input logic [31:0] ea, input logic [31:0] eb,
                           input logic [31:0] na, input logic [31:0] nb);
    check({name, "_a_byp"}, rd_a_byp, ea);
    check({name, "_b_byp"}, rd_b_byp, eb);
    check({name, "_a_nb"}, rd_a_nb, na);
    check({name, "_b_nb"}, rd_b_nb, nb);
  endtask

  function automatic logic [31:0] r0_val(input logic [31:0] v);
    return R0_ZERO ? 32'h0 : v;
  endfunction

  initial begin
    logic [31:0] r0_exp;

    // Table: R5/R9/R7 writes with byte enables, no-op writes and forwarding.
    vecs[0]  = '{1'b1, 4'd5, 4'hF, 32'hAABBCCDD, 4'd5, 4'd3, 32'hAABBCCDD, 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{1'b1, 4'd5, 4'h5, 32'h11223344, 4'd5, 4'd5, 32'hAA22CC44, 32'hAA22CC44, 32'hAABBCCDD, 32'hAABBCCDD};
    vecs[2]  = '{1'b0, 4'd5, 4'hF, 32'h0,        4'd5, 4'd5, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44};
    vecs[3]  = '{1'b1, 4'd5, 4'h0, 32'hFFFFFFFF, 4'd5, 4'd3, 32'hAA22CC44, 32'h0, 32'hAA22CC44, 32'h0};
    vecs[4]  = '{1'b0, 4'd0, 4'h0, 32'h0,        4'd5, 4'd7, 32'hAA22CC44, 32'h0, 32'hAA22CC44, 32'h0};
    vecs[5]  = '{1'b1, 4'd9, 4'hF, 32'h01020304, 4'd9, 4'd5, 32'h01020304, 32'hAA22CC44, 32'h0, 32'hAA22CC44};
    vecs[6]  = '{1'b1, 4'd9, 4'h8, 32'hFF000000, 4'd5, 4'd9, 32'hAA22CC44, 32'hFF020304, 32'hAA22CC44, 32'h01020304};
    vecs[7]  = '{1'b1, 4'd9, 4'h2, 32'h0000AB00, 4'd9, 4'd9, 32'hFF02AB04, 32'hFF02AB04, 32'hFF020304, 32'hFF020304};
    vecs[8]  = '{1'b0, 4'd9, 4'hF, 32'h0,        4'd9, 4'd5, 32'hFF02AB04, 32'hAA22CC44, 32'hFF02AB04, 32'hAA22CC44};
    vecs[9]  = '{1'b1, 4'd7, 4'hF, 32'hCAFEF00D, 4'd7, 4'd7, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0, 32'h0};
    vecs[10] = '{1'b0, 4'd7, 4'h0, 32'h0,        4'd7, 4'd7, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D};

    // Clock/reset.
    clear = 1'b1;
    drive(1'b0, 4'd0, 4'h0, 32'h0, 4'd0, 4'd0);
    repeat (2) tick();
    clear = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i);
      rd_addr_b = 4'(15 - i);
      #1;
      check_all("reset", 32'h0, 32'h0, 32'h0, 32'h0);
    end

    // Table-driven vectors: checked just before the edge that commits the write.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].be, vecs[i].wd, vecs[i].ra, vecs[i].rb);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].na, vecs[i].nb);
      tick();
    end

    // Asynchronous clear mid-cycle, then clear held across an edge with a write pending.
    drive(1'b1, 4'd3, 4'hF, 32'hDEADBEEF, 4'd3, 4'd3);
    tick();
    drive(1'b0, 4'd3, 4'h0, 32'h0, 4'd3, 4'd3);
    #1;
    check_all("r3_deadbeef", 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    #1;
    clear = 1'b1;
    #1;
    check_all("async_clear", 32'h0, 32'h0, 32'h0, 32'h0);
    drive(1'b1, 4'd2, 4'hF, 32'hFFFFFFFF, 4'd2, 4'd3);
    #1;
    check_all("clear_no_bypass", 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    drive(1'b0, 4'd2, 4'h0, 32'h0, 4'd2, 4'd3);
    clear = 1'b0;
    #1;
    check_all("clear_beats_write", 32'h0, 32'h0, 32'h0, 32'h0);
    drive(1'b1, 4'd3, 4'hF, 32'h12345678, 4'd7, 4'd9);
    #1;
    check_all("cleared_others", 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    drive(1'b0, 4'd3, 4'h0, 32'h0, 4'd3, 4'd3);
    #1;
    check_all("r3_after_clear", 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678);

    // Register 0 write: same-cycle and after the edge.
    drive(1'b1, 4'd0, 4'hF, 32'h55555555, 4'd0, 4'd0);
    #1;
    r0_exp = r0_val(32'h55555555);
    check_all("r0_same_cycle", r0_exp, r0_exp, 32'h0, 32'h0);
    tick();
    drive(1'b0, 4'd0, 4'h0, 32'h0, 4'd0, 4'd0);
    #1;
    check_all("r0_after", r0_exp, r0_exp, r0_exp, r0_exp);

    // Fill all registers, then sweep A ascending and B descending.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 4'hF, 32'h100 + 32'(i), 4'd0, 4'd0);
      tick();
    end
    wr_en = 1'b0;
    for (int a = 0; a < 16; a++) begin
      logic [31:0] ea, eb;
      rd_addr_a = 4'(a);
      rd_addr_b = 4'(15 - a);
      ea = (a == 0) ? r0_val(32'h100) : 32'h100 + 32'(a);
      eb = (a == 15) ? r0_val(32'h100) : 32'h100 + 32'(15 - a);
      #1;
      check_all($sformatf("sweep%0d", a), ea, eb, ea, eb);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_bank.md
Name: regfile_bank

Overview:
- Parametrised multi-register storage block; next generation of the single 32-bit enable/clear register.
- Holds NUM_REGS words of DATA_WIDTH bits, with one byte-enabled write port and two independent read ports (A/B).
- Sits between the datapath bus and the ALU operand muxes and replaces discrete per-register instances (R0..R15).

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- NUM_REGS, 16, number of registers; power of two, at least 2.
- ADDR_WIDTH, $clog2(NUM_REGS), register index width; derived, do not override.
- BYPASS, 1, 1 = write-through forwarding onto read ports in the same cycle; 0 = reads show stored value only.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- clear  in  1  asynchronous, active-high reset; zeroes every register.
- wr_en  in  1  write strobe, sampled at posedge.
- wr_addr  in  ADDR_WIDTH  destination register index.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i].
- wr_data  in  DATA_WIDTH  write data.
- rd_addr_a  in  ADDR_WIDTH  read port A index.
- rd_data_a  out  DATA_WIDTH  read port A data (combinational).
- rd_addr_b  in  ADDR_WIDTH  read port B index.
- rd_data_b  out  DATA_WIDTH  read port B data (combinational).

Behaviour:
- Reset:
  - clear high: all registers go to 0 immediately, independent of clock; rd_data_a and rd_data_b read 0.
  - Writes are ignored while clear is high.
  - On clear deassertion, the first write takes effect at the first posedge where clear is low.
- Write:
  - At posedge with wr_en=1, each byte lane i with wr_be[i]=1 loads the matching wr_data byte into reg[wr_addr]; lanes with wr_be[i]=0 hold.
  - wr_en=1 with wr_be all-zero is a no-op.
  - Write latency is 1 cycle: the stored value is visible from the next cycle.
- Read:
  - Purely combinational from storage and addresses; zero latency.
  - Both ports may address the same register.
- Bypass (BYPASS=1):
  - Applies when wr_en=1 and rd_addr_x==wr_addr.
  - rd_data_x = stored word with enabled lanes replaced by wr_data lanes, i.e. the value the register will hold after the edge.
  - Applies independently to A and B.
  - No bypass while clear is high; output is 0.
- BYPASS=0: reads return the pre-edge stored value; the new value appears the cycle after the write.
- Out-of-range addresses cannot occur because NUM_REGS is a power of two.
- Simultaneous clear and wr_en: clear wins and the register stays 0.
- No X on outputs after the first clear. Before any clear, contents are simulation-undefined; the bench must assert clear first.

Optional Feature:
- Macro: REGFILE_R0_ZERO_EN.
- Defined:
  - Register index 0 is hardwired to 0; writes to index 0 are discarded.
  - Reads of index 0 return 0 on both ports, with no bypass for index 0.
  - Synthesis must not infer storage for reg[0].
- Undefined: register 0 is an ordinary register, identical to the others.

Decomposition:
- Package regfile_pkg:
  - Constant REGFILE_DATA_WIDTH=32 and REGFILE_NUM_REGS=16.
  - Function computing the byte-lane count.
  - Typedef for the byte-enable vector.
  - Function merge_bytes(old, new, be) returning the lane-merged word; used by both the write path and the bypass path.
- Sub-module regfile_cell:
  - One DATA_WIDTH register with async clear, a per-byte enable vector and a merged next-value output.
  - Instantiated NUM_REGS times via generate; index 0 is skipped under REGFILE_R0_ZERO_EN.
  - Top level owns address decode and the two read muxes plus bypass.

Test Plan:
- Reset: write 0xDEADBEEF to R3, pulse clear mid-cycle without a clock edge -> rd_data_a (addr 3) reads 0x00000000 immediately. Then write 0x12345678 to R3 -> reads 0x12345678 next cycle.
- Byte enables: R5=0xAABBCCDD; write 0x11223344 with wr_be=4'b0101 -> R5 reads 0xAA22CC44.
- Bypass, BYPASS=1: R7=0x0; in the same cycle, wr_en=1, wr_addr=7, wr_data=0xCAFEF00D, wr_be=4'hF, rd_addr_a=rd_addr_b=7 -> both read 0xCAFEF00D that cycle. Repeat with BYPASS=0 -> 0x0 that cycle, 0xCAFEF00D next cycle.
- Simultaneous clear and write: clear=1 with wr_en=1, wr_addr=2, wr_data=0xFFFFFFFF across a posedge -> R2 reads 0 after clear drops.
- R0, macro defined: write 0x55555555 to R0 -> both ports read 0 in the same cycle and afterwards. Macro undefined -> 0x55555555 after the edge.
- Dual-port independence: fill R0..R15 with 0x100+i -> sweep rd_addr_a ascending and rd_addr_b descending; every cycle A=0x100+a and B=0x100+b.
